// File: rtl/comp_ascii_tx.sv
// Streams two operands as ASCII bit lines ("ab\n", MSB first) followed by a
// G/E/L result line, deciding the magnitude comparison one bit pair at a time.
module comp_ascii_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_one,
    input  logic [WIDTH-1:0] in_two,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             res_gt,
    output logic             res_eq,
    output logic             res_lt
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHAR_A,
        CHAR_B,
        NL_BIT,
        RES_CHAR,
        RES_NL
    } state_t;

    state_t           state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             decided, decided_d;
    logic             gt_q, gt_d;
    logic [7:0]       char_d;
    logic             done_d;
    logic [2:0]       res_d;
    logic             xfer, accept;

    assign xfer   = out_valid && out_ready;
    assign accept = in_valid && in_ready;

    // Next-state logic; the outgoing byte is derived from the next state so
    // every output can be registered without an extra cycle of latency.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        a_d       = a_q;
        b_d       = b_q;
        decided_d = decided;
        gt_d      = gt_q;
        done_d    = 1'b0;
        res_d     = {res_gt, res_eq, res_lt};
        char_d    = 8'h00;

        case (state)
            IDLE: begin
                if (accept) begin
                    a_d       = in_one;
                    b_d       = in_two;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    idx_d     = IW'(WIDTH - 1);
                    res_d     = 3'b000;
                    state_d   = CHAR_A;
                end
            end
            CHAR_A: begin
                if (xfer) state_d = CHAR_B;
            end
            CHAR_B: begin
                if (xfer) begin
                    // Only the first differing bit from the MSB decides.
                    if (!decided && (a_q[idx] != b_q[idx])) begin
                        decided_d = 1'b1;
                        gt_d      = a_q[idx];
                    end
                    state_d = NL_BIT;
                end
            end
            NL_BIT: begin
                if (xfer) begin
                    if (idx == '0) begin
                        state_d = RES_CHAR;
                    end else begin
                        idx_d   = idx - IW'(1);
                        state_d = CHAR_A;
                    end
                end
            end
            RES_CHAR: begin
                if (xfer) state_d = RES_NL;
            end
            RES_NL: begin
                if (xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    res_d   = !decided ? 3'b010 : (gt_q ? 3'b100 : 3'b001);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            CHAR_A:   char_d = 8'h30 + {7'b0, a_d[idx_d]};
            CHAR_B:   char_d = 8'h30 + {7'b0, b_d[idx_d]};
            NL_BIT:   char_d = 8'h0A;
            RES_CHAR: char_d = !decided_d ? 8'h45 : (gt_d ? 8'h47 : 8'h4C);
            RES_NL:   char_d = 8'h0A;
            default:  char_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= IW'(WIDTH - 1);
            a_q       <= '0;
            b_q       <= '0;
            decided   <= 1'b0;
            gt_q      <= 1'b0;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            done      <= 1'b0;
            res_gt    <= 1'b0;
            res_eq    <= 1'b0;
            res_lt    <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            decided   <= decided_d;
            gt_q      <= gt_d;
            out_char  <= char_d;
            out_valid <= (state_d != IDLE);
            busy      <= (state_d != IDLE);
            in_ready  <= (state_d == IDLE);
            done      <= done_d;
            {res_gt, res_eq, res_lt} <= res_d;
        end
    end

endmodule

// File: tb/tb_comp_ascii_tx.sv
// Directed bench for comp_ascii_tx at WIDTH=4: streams, backpressure,
// busy rejection, back-to-back acceptance and reset behaviour.
module tb_comp_ascii_tx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in_one = '0;
    logic [WIDTH-1:0] in_two = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       out_char;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             busy;
    logic             done;
    logic             res_gt;
    logic             res_eq;
    logic             res_lt;

    comp_ascii_tx #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_one   (in_one),
        .in_two   (in_two),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_char (out_char),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .res_gt   (res_gt),
        .res_eq   (res_eq),
        .res_lt   (res_lt)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    logic [7:0] exp_gt [14] = '{8'h31, 8'h31, 8'h0A, 8'h30, 8'h30, 8'h0A, 8'h31,
                                8'h30, 8'h0A, 8'h30, 8'h31, 8'h0A, 8'h47, 8'h0A};
    logic [7:0] exp_eq [14] = '{8'h30, 8'h30, 8'h0A, 8'h31, 8'h31, 8'h0A, 8'h31,
                                8'h31, 8'h0A, 8'h30, 8'h30, 8'h0A, 8'h45, 8'h0A};
    logic [7:0] exp_lt [14] = '{8'h30, 8'h31, 8'h0A, 8'h30, 8'h30, 8'h0A, 8'h31,
                                8'h30, 8'h0A, 8'h31, 8'h30, 8'h0A, 8'h4C, 8'h0A};

    logic [7:0] got [32];
    int         n, cycles, unstable, bad_status, done_seen;
    logic       saw_done;
    logic [2:0] res;

    task automatic accept_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        in_one   = a;
        in_two   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Collects transferred bytes and tallies handshake anomalies; no verdicts here.
    task automatic capture(input int max_bytes, input bit rand_ready,
                           input bit keep_valid, input int inject_at);
        logic       hold;
        logic [7:0] held;
        for (int i = 0; i < 32; i++) got[i] = 8'hxx;
        n = 0; cycles = 0; unstable = 0; bad_status = 0; done_seen = 0;
        hold = 1'b0; held = 8'h00;
        while (n < max_bytes && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (hold && (out_valid !== 1'b1 || out_char !== held)) unstable++;
            if (busy !== 1'b1 || in_ready !== 1'b0) bad_status++;
            if (done === 1'b1) done_seen++;
            if (n == inject_at) begin
                in_valid = 1'b1;
                in_one   = 4'b0000;
                in_two   = 4'b1111;
            end else if (!keep_valid) begin
                in_valid = 1'b0;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = out_valid && !out_ready;
            held = out_char;
            if (out_valid === 1'b1 && out_ready) begin
                got[n] = out_char;
                n++;
            end
        end
    endtask

    task automatic finish_txn;
        @(negedge clk);
        saw_done  = done;
        res       = {res_gt, res_eq, res_lt};
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        #3 rst = 1'b1;
        #1;
        nchecks++;
        if (in_ready !== 1'b1) begin nerrors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        nchecks++;
        if (out_valid !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        nchecks++;
        if (busy !== 1'b0 || done !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        nchecks++;
        if (out_char !== 8'h00 || {res_gt, res_eq, res_lt} !== 3'b000) begin
            nerrors++; $display("[TB] FAIL reset_char_res: got %h/%b expected 00/000", out_char, {res_gt, res_eq, res_lt});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_gt;
        accept_txn(4'b1010, 4'b1001);
        capture(14, 1'b0, 1'b0, -1);
        nchecks++;
        if (n !== 14 || cycles !== 14) begin nerrors++; $display("[TB] FAIL gt_timing: got %0d bytes in %0d cycles expected 14/14", n, cycles); end
        for (int i = 0; i < 14; i++) begin
            nchecks++;
            if (got[i] !== exp_gt[i]) begin nerrors++; $display("[TB] FAIL gt_byte%0d: got %h expected %h", i, got[i], exp_gt[i]); end
        end
        nchecks++;
        if (bad_status !== 0 || done_seen !== 0) begin nerrors++; $display("[TB] FAIL gt_status: got %0d/%0d expected 0/0", bad_status, done_seen); end
        finish_txn();
        nchecks++;
        if (saw_done !== 1'b1 || res !== 3'b100) begin nerrors++; $display("[TB] FAIL gt_done_res: got %b/%b expected 1/100", saw_done, res); end
        nchecks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            nerrors++; $display("[TB] FAIL gt_idle_flags: got %b%b%b expected 001", out_valid, busy, in_ready);
        end
        @(negedge clk);
        nchecks++;
        if (done !== 1'b0 || {res_gt, res_eq, res_lt} !== 3'b100) begin
            nerrors++; $display("[TB] FAIL gt_done_pulse: got %b/%b expected 0/100", done, {res_gt, res_eq, res_lt});
        end
    endtask

    task automatic test_eq;
        accept_txn(4'b0110, 4'b0110);
        capture(14, 1'b0, 1'b0, -1);
        for (int i = 0; i < 14; i++) begin
            nchecks++;
            if (got[i] !== exp_eq[i]) begin nerrors++; $display("[TB] FAIL eq_byte%0d: got %h expected %h", i, got[i], exp_eq[i]); end
        end
        finish_txn();
        nchecks++;
        if (saw_done !== 1'b1 || res !== 3'b010) begin nerrors++; $display("[TB] FAIL eq_done_res: got %b/%b expected 1/010", saw_done, res); end
    endtask

    task automatic test_lt;
        accept_txn(4'b0011, 4'b1000);
        capture(14, 1'b0, 1'b0, -1);
        for (int i = 0; i < 14; i++) begin
            nchecks++;
            if (got[i] !== exp_lt[i]) begin nerrors++; $display("[TB] FAIL lt_byte%0d: got %h expected %h", i, got[i], exp_lt[i]); end
        end
        finish_txn();
        nchecks++;
        if (saw_done !== 1'b1 || res !== 3'b001) begin nerrors++; $display("[TB] FAIL lt_done_res: got %b/%b expected 1/001", saw_done, res); end
    endtask

    task automatic test_backpressure;
        accept_txn(4'b1010, 4'b1001);
        capture(14, 1'b1, 1'b0, -1);
        nchecks++;
        if (n !== 14) begin nerrors++; $display("[TB] FAIL bp_count: got %0d expected 14", n); end
        for (int i = 0; i < 14; i++) begin
            nchecks++;
            if (got[i] !== exp_gt[i]) begin nerrors++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, got[i], exp_gt[i]); end
        end
        nchecks++;
        if (unstable !== 0) begin nerrors++; $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        finish_txn();
        nchecks++;
        if (saw_done !== 1'b1 || res !== 3'b100) begin nerrors++; $display("[TB] FAIL bp_done_res: got %b/%b expected 1/100", saw_done, res); end
    endtask

    task automatic test_busy_reject;
        accept_txn(4'b1010, 4'b1001);
        capture(14, 1'b0, 1'b0, 5);
        for (int i = 0; i < 14; i++) begin
            nchecks++;
            if (got[i] !== exp_gt[i]) begin nerrors++; $display("[TB] FAIL busy_byte%0d: got %h expected %h", i, got[i], exp_gt[i]); end
        end
        finish_txn();
        nchecks++;
        if (saw_done !== 1'b1 || res !== 3'b100) begin nerrors++; $display("[TB] FAIL busy_done_res: got %b/%b expected 1/100", saw_done, res); end
    endtask

    task automatic test_back_to_back;
        accept_txn(4'b1010, 4'b1001);
        in_one   = 4'b0011;
        in_two   = 4'b1000;
        in_valid = 1'b1;
        capture(14, 1'b0, 1'b1, -1);
        for (int i = 0; i < 14; i++) begin
            nchecks++;
            if (got[i] !== exp_gt[i]) begin nerrors++; $display("[TB] FAIL b2b_first_byte%0d: got %h expected %h", i, got[i], exp_gt[i]); end
        end
        finish_txn();
        nchecks++;
        if (saw_done !== 1'b1 || in_ready !== 1'b1) begin nerrors++; $display("[TB] FAIL b2b_done_ready: got %b%b expected 11", saw_done, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        capture(14, 1'b0, 1'b0, -1);
        nchecks++;
        if (cycles !== 14) begin nerrors++; $display("[TB] FAIL b2b_second_cycles: got %0d expected 14", cycles); end
        for (int i = 0; i < 14; i++) begin
            nchecks++;
            if (got[i] !== exp_lt[i]) begin nerrors++; $display("[TB] FAIL b2b_second_byte%0d: got %h expected %h", i, got[i], exp_lt[i]); end
        end
        finish_txn();
        nchecks++;
        if (saw_done !== 1'b1 || res !== 3'b001) begin nerrors++; $display("[TB] FAIL b2b_done_res: got %b/%b expected 1/001", saw_done, res); end
    endtask

    task automatic test_reset_mid_stream;
        int dones;
        accept_txn(4'b1010, 4'b1001);
        capture(7, 1'b0, 1'b0, -1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        nchecks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            nerrors++; $display("[TB] FAIL midrst_flags: got %b%b%b expected 001", out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) dones++;
        end
        nchecks++;
        if (dones !== 0) begin nerrors++; $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", dones); end
        accept_txn(4'b1010, 4'b1001);
        capture(14, 1'b0, 1'b0, -1);
        for (int i = 0; i < 14; i++) begin
            nchecks++;
            if (got[i] !== exp_gt[i]) begin nerrors++; $display("[TB] FAIL midrst_byte%0d: got %h expected %h", i, got[i], exp_gt[i]); end
        end
        finish_txn();
        nchecks++;
        if (saw_done !== 1'b1 || res !== 3'b100) begin nerrors++; $display("[TB] FAIL midrst_done_res: got %b/%b expected 1/100", saw_done, res); end
    endtask

    initial begin
        test_reset();
        test_gt();
        test_eq();
        test_lt();
        test_backpressure();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/comp_ascii_tx.md
Name: comp_ascii_tx

Overview:
Streaming ASCII writer for operand pairs and their comparison result. It accepts two WIDTH-bit operands over a valid/ready handshake. It then emits a byte stream in the comparator line format, one byte per transfer: one "ab\n" line per bit (MSB first, '0'/'1' characters), followed by a result line "G\n", "E\n" or "L\n". The magnitude comparison is evaluated serially, one bit pair per line, so the block produces the same line stream the comparator file benches consume.

Parameters:
WIDTH, 8, operand width in bits (>=1); the bit-index counter is clog2(WIDTH) bits, minimum 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_one  input  WIDTH  operand A
in_two  input  WIDTH  operand B
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
out_char  output  8  ASCII byte
out_valid  output  1  out_char valid
out_ready  input  1  downstream accepts out_char
busy  output  1  transaction in progress
done  output  1  one-cycle pulse after final '\n' transfer
res_gt  output  1  A>B, valid while done=1
res_eq  output  1  A==B, valid while done=1
res_lt  output  1  A<B, valid while done=1

Behaviour:
- One clock. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: in_ready=1, out_valid=0, out_char=8'h00, busy=0, done=0, res_*=0, FSM=IDLE, bit index=WIDTH-1, decided=0.
- FSM states: IDLE, CHAR_A, CHAR_B, NL_BIT, RES_CHAR, RES_NL.
- IDLE: in_ready=1. When in_valid&&in_ready, the block latches in_one/in_two, clears decided/result, sets the index to WIDTH-1 and goes to CHAR_A. On the next cycle out_valid=1 with the first byte and busy=1 (latency 1 cycle).
- Byte transfer occurs on out_valid&&out_ready. While out_valid&&!out_ready, out_char and out_valid are held stable. The state advances only on a transfer.
- CHAR_A: out_char = 8'h30 + A[idx]. Transfer -> CHAR_B.
- CHAR_B: out_char = 8'h30 + B[idx]. On transfer, if !decided and A[idx]!=B[idx]: decided=1, result = A[idx] ? GT : LT. Then -> NL_BIT.
- NL_BIT: out_char = 8'h0A. On transfer, if idx==0 -> RES_CHAR, else idx-1 -> CHAR_A.
- RES_CHAR: out_char = 8'h47 'G' (GT), 8'h4C 'L' (LT), or 8'h45 'E' if !decided. Transfer -> RES_NL.
- RES_NL: out_char = 8'h0A. On transfer -> IDLE. On the following cycle: out_valid=0, busy=0, in_ready=1, done=1 for exactly one cycle, and res_gt/eq/lt show the one-hot result. res_* are held until the next acceptance.
- Total bytes per transaction: 3*WIDTH+2. With out_ready tied high, a transaction occupies exactly 3*WIDTH+2 cycles after acceptance.
- in_ready=0 in every non-IDLE state. in_valid is ignored while busy; operands are never overwritten mid-transaction.
- No same-cycle re-accept: the earliest next acceptance is the cycle done=1.
- The first differing bit, MSB first, is sticky; later bits never change the result.
- WIDTH=1: one bit line, then the result line.
- Reset mid-transaction: immediate return to IDLE with reset values. The partial stream is abandoned; no result line and no done pulse.
- out_ready toggling arbitrarily must not drop, duplicate or reorder bytes.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> outputs reach reset values immediately (in_ready=1, out_valid=0, busy=0).
- WIDTH=4, A=4'b1010, B=4'b1001, out_ready=1 -> bytes 31 31 0A 30 30 0A 31 30 0A 30 31 0A 47 0A over 14 cycles; done pulse with res_gt=1.
- WIDTH=4, A=B=4'b0110 -> bit lines "00","11","11","00", then 45 0A; res_eq=1. Separately, A=4'b0011, B=4'b1000 -> first line "01", then 4C 0A; res_lt=1 despite A having more low ones.
- Backpressure: repeat the 1010/1001 case with out_ready toggling on a pseudo-random pattern -> identical 14-byte sequence; out_char stable whenever out_valid&&!out_ready.
- Busy rejection: pulse in_valid with new operands during byte 5 -> ignored, and the stream is unchanged. A second transaction presented with in_valid held high is accepted on the done cycle.
- Reset mid-stream: assert rst after byte 7 -> out_valid falls asynchronously and no done pulse occurs. A fresh transaction afterwards emits the full, correct stream.
